// File: rtl/resource_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// resource_arbiter_pkg
// Shared definitions for the resource arbiter: FSM state encoding, the
// default memory read latency and a width helper that stays safe for
// degenerate parameter values.
// ---------------------------------------------------------------------------
package resource_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_READ_LAT = 2;

    // $clog2 returns 0 for n<=1, which would give zero-width vectors.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resource_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin select. Picks the first set bit of active_i at or
// after ptr_i, wrapping modulo N_REQ.
//
// Ports:
//   active_i    - request vector, one bit per branch
//   ptr_i       - index holding the highest priority this cycle
//   grant_o     - one-hot grant (all zero when nothing is active)
//   idx_o       - binary index of the granted branch
//   any_valid_o - at least one branch is active
// ---------------------------------------------------------------------------
module rr_arbiter
    import resource_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = safe_clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] active_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_valid_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % N_REQ);
            if (!found && active_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_valid_o = |active_i;

endmodule

// File: rtl/resource_arbiter.sv
// ---------------------------------------------------------------------------
// resource_arbiter
// Collects read/write requests from N_REQ branches, grants them one at a time
// in round-robin order onto a single shared resource-memory port, and returns
// a one-cycle read_ready (with data_out) or write_ack pulse to the winner.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   enable                - global stall; low freezes all state and outputs
//   req_read/req_write    - per-branch level requests, held until completion
//   req_handle/arg_a/arg_b- flattened per-branch handle, address, write data
//   read_ready/write_ack  - one-hot completion pulses
//   data_out              - last captured read data
//   mem_ready             - memory can accept a command this cycle
//   mem_en/mem_we         - command strobe and write select
//   mem_handle/addr/wdata - command fields of the granted branch
//   mem_rdata             - read data, valid READ_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module resource_arbiter
    import resource_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int HANDLE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LAT     = DEFAULT_READ_LAT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [N_REQ-1:0]              req_read,
    input  logic [N_REQ-1:0]              req_write,
    input  logic [N_REQ*HANDLE_WIDTH-1:0] req_handle,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_arg_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_arg_b,
    output logic [N_REQ-1:0]              read_ready,
    output logic [N_REQ-1:0]              write_ack,
    output logic [DATA_WIDTH-1:0]         data_out,
    input  logic                          mem_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [HANDLE_WIDTH-1:0]       mem_handle,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int IDX_W = safe_clog2(N_REQ);
    localparam int CNT_W = safe_clog2(READ_LAT);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [HANDLE_WIDTH-1:0] handle_q, handle_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_write_q, is_write_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [N_REQ-1:0]        read_ready_q, read_ready_d;
    logic [N_REQ-1:0]        write_ack_q, write_ack_d;

    logic [N_REQ-1:0]        active;
    logic [N_REQ-1:0]        gnt_onehot;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_any;

    assign active = req_read | req_write;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .active_i    (active),
        .ptr_i       (ptr_q),
        .grant_o     (gnt_onehot),
        .idx_o       (gnt_idx),
        .any_valid_o (gnt_any)
    );

    // State register: every register, outputs included, lives here so that
    // enable low freezes the whole block in one place.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            handle_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            read_ready_q <= '0;
            write_ack_q  <= '0;
        end else if (enable) begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            handle_q     <= handle_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            read_ready_q <= read_ready_d;
            write_ack_q  <= write_ack_d;
        end
    end

    // Next-state and transaction latch. Requests are only looked at in IDLE;
    // a port raising both read and write is treated as a write.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        handle_d   = handle_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_any && mem_ready) begin
                    idx_d      = gnt_idx;
                    handle_d   = req_handle[int'(gnt_idx)*HANDLE_WIDTH +: HANDLE_WIDTH];
                    addr_d     = req_arg_a[int'(gnt_idx)*DATA_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_arg_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    is_write_d = |(req_write & gnt_onehot);
                    ptr_d      = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
                    state_d    = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (is_write_q) begin
                    state_d = ARB_RESP;
                end else begin
                    cnt_d   = CNT_W'(READ_LAT-1);
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // Capturing when the counter reads zero lands exactly
                // READ_LAT cycles after the mem_en cycle.
                if (cnt_q == '0) begin
                    data_d  = mem_rdata;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line
    // up with the state they belong to.
    always_comb begin
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        read_ready_d = '0;
        write_ack_d  = '0;
        case (state_d)
            ARB_ISSUE: begin
                mem_en_d = 1'b1;
                mem_we_d = is_write_d;
            end
            ARB_RESP: begin
                if (is_write_d) begin
                    write_ack_d = N_REQ'(1) << idx_d;
                end else begin
                    read_ready_d = N_REQ'(1) << idx_d;
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_handle = handle_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign data_out   = data_q;
    assign read_ready = read_ready_q;
    assign write_ack  = write_ack_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// ---------------------------------------------------------------------------
// tb_resource_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model of
// the round-robin grant and the shared memory predicts each command and
// pushes the expected completion into a scoreboard that a monitor drains.
// ---------------------------------------------------------------------------
module tb_resource_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int HW  = 8;
    localparam int AW  = 12;
    localparam int LAT = 2;

    typedef struct {
        int          port;
        bit          isWrite;
        logic [DW-1:0] data;
        int          due;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [DW-1:0] val;
    } rsp_t;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [N-1:0]    req_read, req_write, read_ready, write_ack;
    logic [N*HW-1:0] req_handle;
    logic [N*DW-1:0] req_arg_a, req_arg_b;
    logic [DW-1:0]   data_out, mem_wdata, mem_rdata;
    logic            mem_ready, mem_en, mem_we;
    logic [HW-1:0]   mem_handle;
    logic [AW-1:0]   mem_addr;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    bit            reqRd[N];
    bit            reqWr[N];
    logic [HW-1:0] reqH[N];
    logic [DW-1:0] reqA[N];
    logic [DW-1:0] reqB[N];

    bit resetReq     = 1'b1;
    bit contReads    = 1'b0;
    bit randomReqs   = 1'b0;
    bit randomEnable = 1'b0;
    int memReadyMode = 1;

    logic [N-1:0]  doneMask    = '0;
    exp_t          scoreQ[$];
    rsp_t          rspQ[$];
    logic [DW-1:0] memStore[int];
    int            modelPtr    = 0;
    int            freeFrom    = 0;
    bit            expectGrant = 1'b0;
    bit            lastReset   = 1'b0;
    logic [N-1:0]  lastPending = '0;
    logic [DW-1:0] lastData    = '0;

    resource_arbiter #(
        .N_REQ        (N),
        .DATA_WIDTH   (DW),
        .HANDLE_WIDTH (HW),
        .ADDR_WIDTH   (AW),
        .READ_LAT     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_handle (req_handle),
        .req_arg_a  (req_arg_a),
        .req_arg_b  (req_arg_b),
        .read_ready (read_ready),
        .write_ack  (write_ack),
        .data_out   (data_out),
        .mem_ready  (mem_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_handle (mem_handle),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int memKey(input logic [HW-1:0] h, input logic [AW-1:0] a);
        return int'({h, a});
    endfunction

    function automatic logic [DW-1:0] memRead(input int k);
        if (memStore.exists(k)) return memStore[k];
        return DW'((k * 40503) ^ 32'h0000_A5C3);
    endfunction

    function automatic logic [N-1:0] activeVec();
        logic [N-1:0] v;
        for (int p = 0; p < N; p++) v[p] = reqRd[p] | reqWr[p];
        return v;
    endfunction

    // Reference round-robin: first requesting port at or after the pointer.
    function automatic int rrPick(input logic [N-1:0] vec, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (vec[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // kind: 0 = read, 1 = write, 2 = read and write together
    task automatic newRequest(input int p, input int kind, input logic [HW-1:0] h,
                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        reqRd[p] = (kind != 1);
        reqWr[p] = (kind != 0);
        reqH[p]  = h;
        reqA[p]  = a;
        reqB[p]  = b;
    endtask

    task automatic applyStimulus();
        reset = resetReq;
        for (int p = 0; p < N; p++) begin
            req_read[p]  = reqRd[p];
            req_write[p] = reqWr[p];
            if (reqRd[p] || reqWr[p]) begin
                req_handle[p*HW +: HW] = reqH[p];
                req_arg_a[p*DW +: DW]  = reqA[p];
                req_arg_b[p*DW +: DW]  = reqB[p];
            end else begin
                req_handle[p*HW +: HW] = HW'($urandom);
                req_arg_a[p*DW +: DW]  = DW'($urandom);
                req_arg_b[p*DW +: DW]  = DW'($urandom);
            end
        end
    endtask

    // Advance one cycle and drive this cycle's inputs shortly after the edge.
    task automatic stepCycle();
        int kind;
        @(posedge clk);
        #1;
        cycle++;
        for (int p = 0; p < N; p++) begin
            if (doneMask[p]) begin
                reqRd[p] = 1'b0;
                reqWr[p] = 1'b0;
                if (contReads) newRequest(p, 0, HW'($urandom), DW'($urandom), DW'($urandom));
            end
        end
        doneMask = '0;
        if (randomReqs) begin
            for (int p = 0; p < N; p++) begin
                if (!(reqRd[p] || reqWr[p]) && $urandom_range(0, 3) == 0) begin
                    kind = $urandom_range(0, 7);
                    newRequest(p, (kind < 4) ? 0 : ((kind < 7) ? 1 : 2),
                               HW'($urandom_range(0, 3)),
                               {4'($urandom), 12'($urandom_range(0, 15))},
                               DW'($urandom));
                end
            end
        end
        if (memReadyMode == 2) mem_ready = ($urandom_range(0, 3) != 0);
        else                   mem_ready = (memReadyMode == 1);
        enable = 1'b1;
        if (randomEnable && !resetReq && cycle >= freeFrom && !expectGrant &&
            scoreQ.size() == 0 && $urandom_range(0, 9) == 0) begin
            enable = 1'b0;
        end
        while (rspQ.size() > 0 && rspQ[0].cyc < cycle) void'(rspQ.pop_front());
        if (rspQ.size() > 0 && rspQ[0].cyc == cycle) mem_rdata = rspQ[0].val;
        else                                         mem_rdata = DW'($urandom);
        applyStimulus();
    endtask

    task automatic applyReset(input int n);
        resetReq  = 1'b1;
        contReads = 1'b0;
        for (int p = 0; p < N; p++) begin
            reqRd[p] = 1'b0;
            reqWr[p] = 1'b0;
        end
        repeat (n) stepCycle();
        resetReq = 1'b0;
    endtask

    task automatic waitIdle();
        int  n;
        bit  idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < 300) begin
            stepCycle();
            n++;
            idle = (activeVec() == '0) && (scoreQ.size() == 0) && (cycle >= freeFrom);
        end
        if (!idle) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    // Monitor and reference model. Predicts each grant from the requests seen
    // in the previous cycle, plays the memory, and checks completions.
    initial begin : monitor
        exp_t          e;
        int            p;
        bit            isW;
        logic [DW-1:0] expData;
        forever begin
            @(negedge clk);
            if (reset) begin
                scoreQ.delete();
                modelPtr    = 0;
                lastData    = '0;
                freeFrom    = cycle + 1;
                expectGrant = 1'b0;
                lastReset   = 1'b1;
            end else begin
                if (lastReset) begin
                    checkOutput("reset_mem_en", mem_en, 0);
                    checkOutput("reset_read_ready", read_ready, 0);
                    checkOutput("reset_write_ack", write_ack, 0);
                    checkOutput("reset_data_out", data_out, 0);
                    checkOutput("reset_mem_addr", mem_addr, 0);
                    checkOutput("reset_mem_handle", mem_handle, 0);
                end
                lastReset = 1'b0;
                assert (!(scoreQ.size() > 0 && !scoreQ[0].isWrite && !enable))
                    else $error("[TB] enable dropped while a read is outstanding");

                checkOutput("mem_en", mem_en, expectGrant);
                if (mem_en) begin
                    p = rrPick(lastPending, modelPtr);
                    if (p >= 0) begin
                        isW = req_write[p];
                        checkOutput("mem_we", mem_we, isW);
                        checkOutput("mem_handle", mem_handle, req_handle[p*HW +: HW]);
                        checkOutput("mem_addr", mem_addr, req_arg_a[p*DW +: AW]);
                        if (isW) checkOutput("mem_wdata", mem_wdata, req_arg_b[p*DW +: DW]);
                        expData = isW ? '0 : memRead(memKey(req_handle[p*HW +: HW], req_arg_a[p*DW +: AW]));
                        if (mem_we) memStore[memKey(mem_handle, mem_addr)] = mem_wdata;
                        else        rspQ.push_back('{cycle + LAT, memRead(memKey(mem_handle, mem_addr))});
                        e.port    = p;
                        e.isWrite = isW;
                        e.data    = expData;
                        e.due     = cycle + (isW ? 1 : 1 + LAT);
                        scoreQ.push_back(e);
                        freeFrom = e.due + 1;
                        modelPtr = (p + 1) % N;
                    end
                end

                if (|read_ready || |write_ack) begin
                    if (scoreQ.size() == 0) begin
                        checkOutput("unexpected_pulse", {read_ready, write_ack}, 0);
                    end else begin
                        e = scoreQ.pop_front();
                        checkOutput("resp_cycle", cycle, e.due);
                        checkOutput("write_ack", write_ack, e.isWrite ? (32'd1 << e.port) : 32'd0);
                        checkOutput("read_ready", read_ready, e.isWrite ? 32'd0 : (32'd1 << e.port));
                        if (!e.isWrite) begin
                            checkOutput("data_out", data_out, e.data);
                            lastData = e.data;
                        end
                        doneMask[e.port] = 1'b1;
                    end
                end else begin
                    checkOutput("data_out_hold", data_out, lastData);
                end

                if (scoreQ.size() > 0 && cycle > scoreQ[0].due) begin
                    checkOutput("resp_timeout", cycle, scoreQ[0].due);
                    doneMask[scoreQ[0].port] = 1'b1;
                    void'(scoreQ.pop_front());
                end

                lastPending = req_read | req_write;
                expectGrant = enable && mem_ready && (cycle >= freeFrom) && (lastPending != '0);
            end
        end
    end

    initial begin : main
        for (int p = 0; p < N; p++) begin
            reqRd[p] = 1'b0;
            reqWr[p] = 1'b0;
            reqH[p]  = '0;
            reqA[p]  = '0;
            reqB[p]  = '0;
        end
        enable    = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = '0;
        applyStimulus();
        repeat (3) stepCycle();
        resetReq = 1'b0;
        stepCycle();

        $display("[TB] single read on port 2");
        memStore[memKey(8'h05, 12'h123)] = 16'hBEEF;
        newRequest(2, 0, 8'h05, 16'h0123, 16'h1111);
        waitIdle();

        $display("[TB] single write on port 0");
        newRequest(0, 1, 8'h11, 16'h0040, 16'h7FFF);
        waitIdle();

        $display("[TB] continuous reads on all ports from reset");
        applyReset(2);
        contReads = 1'b1;
        for (int p = 0; p < N; p++) newRequest(p, 0, HW'(p + 1), DW'(16'h0200 + p), DW'(0));
        repeat (5 * N + 3) stepCycle();
        contReads = 1'b0;
        waitIdle();

        $display("[TB] write on port 1 behind a mem_ready stall");
        memReadyMode = 0;
        newRequest(1, 1, 8'h22, 16'h0ABC, 16'h1234);
        repeat (3) stepCycle();
        memReadyMode = 1;
        waitIdle();

        $display("[TB] read and write together on port 3");
        newRequest(3, 2, 8'h33, 16'h0077, 16'hCAFE);
        waitIdle();

        $display("[TB] reset during a read wait");
        newRequest(1, 0, 8'h44, 16'h0010, 16'h0000);
        stepCycle();
        stepCycle();
        applyReset(1);
        newRequest(0, 0, 8'h01, 16'h0001, 16'h0000);
        newRequest(3, 0, 8'h02, 16'h0002, 16'h0000);
        waitIdle();

        $display("[TB] randomized traffic");
        randomReqs   = 1'b1;
        randomEnable = 1'b1;
        memReadyMode = 2;
        repeat (800) stepCycle();
        randomReqs   = 1'b0;
        randomEnable = 1'b0;
        memReadyMode = 1;
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
